// File: rtl/ram_pkg.sv
// Shared widths and word type for the Hack-style RAM hierarchy.
package ram_pkg;
    localparam int WORD_W    = 16;
    localparam int RAM512_AW = 9;
    localparam int RAM4K_AW  = 12;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram_512.sv
// 512 x 16 register bank: synchronous write and clear, combinational read.
module ram_512
    import ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [RAM512_AW-1:0] address,
    input  word_t                in,
    output word_t                out
);
    localparam int DEPTH = 1 << RAM512_AW;

    word_t mem_q [DEPTH];

    // Clear wins over load so a reset edge never leaves a stray write behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            mem_q[address] <= in;
        end
    end

    assign out = mem_q[address];
endmodule

// File: rtl/ram_4k.sv
// 4096 x 16 RAM built from eight 512-word banks selected by address[11:9].
module ram_4k
    import ram_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter int DEPTH_LOG2 = RAM4K_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DEPTH_LOG2-1:0] address,
    input  logic [WIDTH-1:0]      in,
    output logic [WIDTH-1:0]      out
);
    localparam int BANK_AW = DEPTH_LOG2 - RAM512_AW;
    localparam int BANKS   = 1 << BANK_AW;

    logic [BANK_AW-1:0]   bank_sel;
    logic [RAM512_AW-1:0] word_sel;
    logic [BANKS-1:0]     bank_load;
    word_t                bank_out [BANKS];

    assign bank_sel = address[DEPTH_LOG2-1:RAM512_AW];
    assign word_sel = address[RAM512_AW-1:0];

    // One-hot load demux; reset reaches every bank regardless of selection.
    assign bank_load = load ? (BANKS'(1) << bank_sel) : '0;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram_512 u_bank (
            .clk     (clk),
            .reset   (reset),
            .load    (bank_load[b]),
            .address (word_sel),
            .in      (in),
            .out     (bank_out[b])
        );
    end

    assign out = bank_out[bank_sel];
endmodule

// File: tb/tb_ram_4k.sv
// Scoreboard bench for ram_4k: expected reads queued with stimulus, compared on readout.
module tb_ram_4k;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] model [4096];

    ram_4k dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .in      (din),
        .out     (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        load    = 1'b1;
        address = a;
        din     = d;
        @(negedge clk);
        load = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4096; i++) model[i] = 16'h0000;
        exp_q.push_back('{12'd0,    16'h0000, "reset_0"});
        exp_q.push_back('{12'd1000, 16'h0000, "reset_1000"});
        exp_q.push_back('{12'd4095, 16'h0000, "reset_4095"});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            address = e.addr;
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, dout, e.data);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        do_write(12'd0,    16'hA000);
        do_write(12'd1000, 16'hB111);
        do_write(12'd2500, 16'hC222);
        do_write(12'd4095, 16'hD333);
        exp_q.push_back('{12'd0,    16'hA000, "wr_rd_0"});
        exp_q.push_back('{12'd1000, 16'hB111, "wr_rd_1000"});
        exp_q.push_back('{12'd2500, 16'hC222, "wr_rd_2500"});
        exp_q.push_back('{12'd4095, 16'hD333, "wr_rd_4095"});
        exp_q.push_back('{12'd4094, 16'h0000, "wr_rd_4094"});
        exp_q.push_back('{12'd1,    16'h0000, "wr_rd_1"});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            address = e.addr;
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, dout, e.data);
            end
        end
    endtask

    task automatic test_overwrite();
        exp_t e;
        do_write(12'd2500, 16'hEEEE);
        exp_q.push_back('{12'd2500, 16'hEEEE, "overwrite_2500"});
        exp_q.push_back('{12'd1000, 16'hB111, "overwrite_1000"});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            address = e.addr;
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, dout, e.data);
            end
        end
    endtask

    task automatic test_bank_isolation();
        exp_t e;
        do_write(12'd511,  16'h1234);
        do_write(12'd512,  16'h5678);
        do_write(12'd3583, 16'h3583);
        do_write(12'd3584, 16'h3584);
        exp_q.push_back('{12'd511,  16'h1234, "bank_511"});
        exp_q.push_back('{12'd512,  16'h5678, "bank_512"});
        exp_q.push_back('{12'd510,  16'h0000, "bank_510"});
        exp_q.push_back('{12'd513,  16'h0000, "bank_513"});
        exp_q.push_back('{12'd3583, 16'h3583, "bank_3583"});
        exp_q.push_back('{12'd3584, 16'h3584, "bank_3584"});
        exp_q.push_back('{12'd3582, 16'h0000, "bank_3582"});
        exp_q.push_back('{12'd3585, 16'h0000, "bank_3585"});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            address = e.addr;
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, dout, e.data);
            end
        end
    endtask

    task automatic test_load_low();
        @(negedge clk);
        load    = 1'b0;
        address = 12'd0;
        din     = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dout !== 16'hA000) begin
                failures++;
                $display("FAIL load_low cycle=%0d got=%h exp=%h", c, dout, 16'hA000);
            end
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        load    = 1'b1;
        address = 12'd0;
        din     = 16'hFFFF;
        #1;
        checks++;
        if (dout !== 16'hA000) begin
            failures++;
            $display("FAIL rdw_before got=%h exp=%h", dout, 16'hA000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 16'hFFFF) begin
            failures++;
            $display("FAIL rdw_after got=%h exp=%h", dout, 16'hFFFF);
        end
        load = 1'b0;
        model[0] = 16'hFFFF;
    endtask

    task automatic test_random_sweep();
        exp_t        e;
        logic [11:0] a;
        for (int i = 0; i < 64; i++) begin
            a = 12'($urandom_range(0, 4095));
            exp_q.push_back('{a, model[a], "sweep"});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            address = e.addr;
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, dout, e.data);
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        @(negedge clk);
        reset   = 1'b1;
        load    = 1'b1;
        address = 12'd4095;
        din     = 16'h9999;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        checks++;
        if (dout !== 16'h0000) begin
            failures++;
            $display("FAIL rst_prio_4095 got=%h exp=%h", dout, 16'h0000);
        end
        for (int i = 0; i < 4096; i++) model[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) begin
            exp_q.push_back('{12'(i), 16'h0000, "rst_prio_all"});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            address = e.addr;
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, dout, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_overwrite();
        test_bank_isolation();
        test_load_low();
        test_read_during_write();
        test_random_sweep();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
